// File: rtl/test_pattern_pkg.sv
// Shared definitions for the IQ test-pattern generator: mode encodings and
// the PRBS polynomial (x^15 + x^14 + 1) seed and tap positions.
package test_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LUT   = 2'd2,
    MODE_PRBS  = 2'd3
  } mode_e;

  localparam logic [14:0] PRBS_SEED  = 15'h0001;
  localparam int unsigned PRBS_TAP_A = 14;
  localparam int unsigned PRBS_TAP_B = 13;

endpackage

// File: rtl/test_pattern_lfsr.sv
// 15-bit Fibonacci LFSR (x^15 + x^14 + 1) with an advance strobe; exposes
// the low OW bits as the PRBS sample. Built only with TEST_PATTERN_PRBS_EN.
module test_pattern_lfsr
  import test_pattern_pkg::*;
#(
  parameter int unsigned OW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [OW-1:0] value
);

  logic [14:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PRBS_SEED;
    end else if (adv) begin
      state <= {state[13:0], state[PRBS_TAP_A] ^ state[PRBS_TAP_B]};
    end
  end

  assign value = state[OW-1:0];

endmodule

// File: rtl/test_pattern_gen.sv
// Runtime-selectable IQ test-pattern source (CONST / RAMP / LUT / PRBS) with a
// valid/ready output stream. PRBS mode is built only when TEST_PATTERN_PRBS_EN is defined.
module test_pattern_gen
  import test_pattern_pkg::*;
#(
  parameter int unsigned DW     = 12,
  parameter int unsigned LUT_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [LUT_AW-1:0] step_i,
  input  logic [2*DW-1:0]   const_i,
  input  logic              lut_we_i,
  input  logic [LUT_AW-1:0] lut_addr_i,
  input  logic [2*DW-1:0]   lut_wdata_i,
  output logic [2*DW-1:0]   m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [31:0]       sample_cnt_o
);

  logic [2*DW-1:0]   lut [0:(2**LUT_AW)-1];
  logic [DW-1:0]     ramp;
  logic [LUT_AW-1:0] lut_idx;
  logic [2*DW-1:0]   next_sample;
  logic              transfer;
  logic              load;
  mode_e             mode;

  assign mode     = mode_e'(mode_i);
  assign transfer = m_valid_o & m_ready_i;
  assign load     = enable_i & (~m_valid_o | transfer);

`ifdef TEST_PATTERN_PRBS_EN
  logic [DW-1:0] prbs;

  test_pattern_lfsr #(.OW(DW)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (load && (mode == MODE_PRBS)),
    .value (prbs)
  );
`endif

  // Table is not reset; a same-cycle load reads the pre-write entry.
  always_ff @(posedge clk) begin
    if (lut_we_i) begin
      lut[lut_addr_i] <= lut_wdata_i;
    end
  end

  always_comb begin
    next_sample = '0;
    case (mode)
      MODE_CONST: next_sample = const_i;
      MODE_RAMP:  next_sample = {ramp, ~ramp};
      MODE_LUT:   next_sample = lut[lut_idx];
`ifdef TEST_PATTERN_PRBS_EN
      MODE_PRBS:  next_sample = {prbs, ~prbs};
`else
      MODE_PRBS:  next_sample = '0;
`endif
      default:    next_sample = '0;
    endcase
  end

  // Each mode's state advances only on loads in that mode and survives switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_o     <= '0;
      m_valid_o    <= 1'b0;
      sample_cnt_o <= '0;
      ramp         <= '0;
      lut_idx      <= '0;
    end else begin
      if (load) begin
        m_data_o  <= next_sample;
        m_valid_o <= 1'b1;
        if (mode == MODE_RAMP) begin
          ramp <= ramp + 1'b1;
        end
        if (mode == MODE_LUT) begin
          lut_idx <= lut_idx + step_i;
        end
      end else if (transfer) begin
        m_valid_o <= 1'b0;
      end
      if (transfer) begin
        sample_cnt_o <= sample_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed self-checking bench for test_pattern_gen (DW=12, LUT_AW=2);
// PRBS expectations depend on TEST_PATTERN_PRBS_EN.
module tb_test_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [1:0]  mode_i;
  logic [1:0]  step_i;
  logic [23:0] const_i;
  logic        lut_we_i;
  logic [1:0]  lut_addr_i;
  logic [23:0] lut_wdata_i;
  logic [23:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] sample_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  test_pattern_gen #(.DW(12), .LUT_AW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .mode_i       (mode_i),
    .step_i       (step_i),
    .const_i      (const_i),
    .lut_we_i     (lut_we_i),
    .lut_addr_i   (lut_addr_i),
    .lut_wdata_i  (lut_wdata_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .sample_cnt_o (sample_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [23:0] lut_init [4];

  initial begin
    lut_init[0] = 24'h7FF000;
    lut_init[1] = 24'h0007FF;
    lut_init[2] = 24'h800000;
    lut_init[3] = 24'h000800;
    enable_i = 1'b0; mode_i = 2'd0; step_i = 2'd0; const_i = '0;
    lut_we_i = 1'b0; lut_addr_i = '0; lut_wdata_i = '0; m_ready_i = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", {31'd0, m_valid_o}, 32'd0);
    check("rst_data", {8'd0, m_data_o}, 32'd0);
    check("rst_cnt", sample_cnt_o, 32'd0);

    // CONST stream
    mode_i = 2'd0; const_i = 24'h7FF000; m_ready_i = 1'b1; enable_i = 1'b1;
    tick();
    check("const_first_valid", {31'd0, m_valid_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("const_data", {8'd0, m_data_o}, 32'h007FF000);
      tick();
    end
    check("const_cnt10", sample_cnt_o, 32'd10);

    // RAMP with ready toggling
    enable_i = 1'b0;
    do_reset();
    mode_i = 2'd1; m_ready_i = 1'b0; enable_i = 1'b1;
    tick();
    check("ramp0", {8'd0, m_data_o}, 32'h00000FFF);
    tick();
    check("ramp0_hold", {8'd0, m_data_o}, 32'h00000FFF);
    m_ready_i = 1'b1;
    tick();
    check("ramp1", {8'd0, m_data_o}, 32'h00001FFE);
    m_ready_i = 1'b0;
    tick();
    check("ramp1_hold", {8'd0, m_data_o}, 32'h00001FFE);
    check("ramp1_hold_valid", {31'd0, m_valid_o}, 32'd1);
    m_ready_i = 1'b1;
    tick();
    check("ramp2", {8'd0, m_data_o}, 32'h00002FFD);
    for (int i = 0; i < 4094; i++) tick();
    check("ramp_wrap", {8'd0, m_data_o}, 32'h00000FFF);
    check("ramp_cnt4096", sample_cnt_o, 32'd4096);

    // LUT
    enable_i = 1'b0; m_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lut_we_i = 1'b1; lut_addr_i = 2'(i); lut_wdata_i = lut_init[i];
      tick();
    end
    lut_we_i = 1'b0;
    mode_i = 2'd2; step_i = 2'd1; m_ready_i = 1'b1; enable_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lut_step1", {8'd0, m_data_o}, {8'd0, lut_init[i]});
    end
    step_i = 2'd2; m_ready_i = 1'b0;
    tick();
    check("lut_step_change_hold", {8'd0, m_data_o}, 32'h00000800);
    m_ready_i = 1'b1;
    tick();
    check("lut_step2_a", {8'd0, m_data_o}, 32'h007FF000);
    tick();
    check("lut_step2_b", {8'd0, m_data_o}, 32'h00800000);
    tick();
    check("lut_step2_c", {8'd0, m_data_o}, 32'h007FF000);

    // Stall with enable dropped, other inputs disturbed
    m_ready_i = 1'b0; enable_i = 1'b0; mode_i = 2'd0; const_i = 24'h123456;
    tick();
    tick();
    check("stall_data", {8'd0, m_data_o}, 32'h007FF000);
    check("stall_valid", {31'd0, m_valid_o}, 32'd1);
    check("stall_cnt", sample_cnt_o, 32'd6);
    m_ready_i = 1'b1;
    tick();
    check("drain_valid", {31'd0, m_valid_o}, 32'd0);
    check("drain_cnt", sample_cnt_o, 32'd7);

    // Async reset mid-stream (lut_idx is 2 here)
    mode_i = 2'd2; step_i = 2'd1; enable_i = 1'b1;
    tick();
    check("lut_idx2", {8'd0, m_data_o}, 32'h00800000);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, m_valid_o}, 32'd0);
    check("async_rst_data", {8'd0, m_data_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("restart_lut0", {8'd0, m_data_o}, 32'h007FF000);
    check("restart_cnt", sample_cnt_o, 32'd0);
    // Write to the entry being loaded: old value must come out
    lut_we_i = 1'b1; lut_addr_i = 2'd1; lut_wdata_i = 24'h123456;
    tick();
    lut_we_i = 1'b0;
    check("lut_rw_old", {8'd0, m_data_o}, 32'h000007FF);

    // PRBS mode
    enable_i = 1'b0;
    do_reset();
    mode_i = 2'd3; m_ready_i = 1'b1; enable_i = 1'b1;
`ifdef TEST_PATTERN_PRBS_EN
    tick();
    check("prbs0", {8'd0, m_data_o}, 32'h00001FFE);
    tick();
    check("prbs1", {8'd0, m_data_o}, 32'h00002FFD);
    tick();
    check("prbs2", {8'd0, m_data_o}, 32'h00004FFB);
`else
    tick();
    check("prbs_off_data", {8'd0, m_data_o}, 32'd0);
    check("prbs_off_valid", {31'd0, m_valid_o}, 32'd1);
    tick();
    check("prbs_off_cnt", sample_cnt_o, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
Name: test_pattern_gen

Overview:
Parametrised IQ test-pattern source for the TX datapath. It replaces fixed-table stimulus with runtime-selectable modes: constant, ramp, loadable LUT tone, and optional PRBS. Output is a valid/ready stream of packed {I,Q} words. It sits in front of the DAC interface / TX FIFO for bring-up and loopback tests.

Parameters:
DW, 12, per-component sample width; legal range 4..15.
LUT_AW, 2, log2 of LUT depth; LUT holds 2**LUT_AW entries.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
enable_i  in  1  generator run request.
mode_i  in  2  pattern select: 0 CONST, 1 RAMP, 2 LUT, 3 PRBS.
step_i  in  LUT_AW  LUT phase increment per sample.
const_i  in  2*DW  CONST-mode word {I,Q}.
lut_we_i  in  1  LUT write strobe.
lut_addr_i  in  LUT_AW  LUT write address.
lut_wdata_i  in  2*DW  LUT write data {I,Q}.
m_data_o  out  2*DW  sample {I[2DW-1:DW], Q[DW-1:0]}.
m_valid_o  out  1  sample valid.
m_ready_i  in  1  downstream ready.
sample_cnt_o  out  32  count of completed transfers.

Behaviour:
Reset (async assert, sync release):
- m_valid_o=0, m_data_o=0, sample_cnt_o=0.
- ramp=0, lut_idx=0, lfsr=15'h0001.
- LUT contents are not reset.

Stream handshake:
- transfer = m_valid_o & m_ready_i.
- load = enable_i & (~m_valid_o | transfer).
- On load: m_data_o <= next sample; m_valid_o <= 1; generator state advances by one sample.
- On transfer without load (enable_i low): m_valid_o <= 0.
- While m_valid_o & ~m_ready_i: m_data_o and m_valid_o are held stable, regardless of enable_i, mode_i or any other input.
- Latency: first valid sample appears the cycle after enable_i is sampled high. With ready held high, throughput is one sample per clock.
- mode_i, step_i and const_i are sampled only at load. A change mid-stream affects the next loaded sample only; the word already presented is never altered.

Modes (sample value computed from state before the advance):
- CONST: const_i.
- RAMP: I=ramp, Q=~ramp. ramp += 1 per load, mod 2**DW.
- LUT: LUT[lut_idx]. lut_idx += step_i per load, mod 2**LUT_AW. step_i=0 repeats a single entry.
- PRBS: I=lfsr[DW-1:0], Q=~lfsr[DW-1:0]. lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]} (x^15+x^14+1), period 32767.
- Each state (ramp, lut_idx, lfsr) advances only while its own mode is selected and is retained across mode switches.

LUT write: synchronous. A load in the same cycle as a write to the same address reads the old entry.

sample_cnt_o: increments on every transfer; wraps 2**32-1 -> 0.

Optional Feature:
TEST_PATTERN_PRBS_EN
- Defined: PRBS mode and the LFSR are implemented as described above.
- Undefined: no LFSR is built. Mode 3 outputs 0 and still handshakes normally.

Decomposition:
- Package test_pattern_pkg holds: mode encodings MODE_CONST/RAMP/LUT/PRBS, PRBS_SEED=15'h0001, PRBS tap positions.
- Sub-module test_pattern_lfsr: 15-bit LFSR with advance strobe and async reset to seed. It is instantiated only under TEST_PATTERN_PRBS_EN.

Test Plan:
(DW=12, LUT_AW=2 throughout)
1. Reset; CONST, const_i=24'h7FF000, ready=1, enable raised -> valid the next cycle; 24'h7FF000 every cycle; sample_cnt_o=10 after 10 transfers.
2. RAMP, ready toggled 1/0 -> sequence 24'h000FFF, 24'h001FFE, 24'h002FFD, with each word held while ready=0. After 4096 transfers the output is 24'h000FFF again.
3. LUT loaded with 7FF000, 0007FF, 800000, 000800:
   - step_i=1 -> repeating 4-cycle sequence.
   - step_i=2 -> alternates 7FF000 / 800000.
   - Switching step mid-stream -> the presented word is unchanged.
4. enable_i dropped while valid=1, ready=0 -> data and valid held. Raise ready -> one transfer, then valid=0 the next cycle.
5. rst asserted mid-stream (LUT mode, lut_idx=2) -> valid=0 and data=0 immediately (async). On restart the first sample is LUT[0] and sample_cnt_o=0.
6. TEST_PATTERN_PRBS_EN defined, PRBS mode -> 24'h001FFE, 24'h002FFD, 24'h004FFB. With the macro undefined, mode 3 gives 24'h000000 with valid=1.
